// File: rtl/vend_sequencer.sv
// Drink vending sequencer: cup drop, heat, brew, change eject, fault hold.
// One shared cycle counter times every wait; it clears on each state entry.
module vend_sequencer #(
    parameter int unsigned BREW_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned CUP_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pay_valid,
    input  logic [1:0] change_code,
    input  logic       cup_sense,
    input  logic       temp_ok,
    input  logic       coin_ack,
    output logic       accept_coins,
    output logic       cup_drop,
    output logic       heater_on,
    output logic       valve_open,
    output logic       coin5_eject,
    output logic       coin10_eject,
    output logic       done,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CUP   = 3'd1,
        S_HEAT  = 3'd2,
        S_BREW  = 3'd3,
        S_CHG5  = 3'd4,
        S_CHG10 = 3'd5,
        S_DONE  = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam logic [7:0] BREW_LAST = 8'(BREW_CYCLES - 1);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] CUP_LAST  = 8'(CUP_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] chg_q, chg_d;

    always_comb begin
        state_d = state_q;
        chg_d   = chg_q;
        case (state_q)
            S_IDLE: begin
                if (pay_valid) begin
                    chg_d   = change_code;
                    state_d = S_CUP;
                end
            end
            S_CUP: begin
                // A cup arriving on the last allowed cycle beats the timeout.
                if (cup_sense)
                    state_d = S_HEAT;
                else if (cnt_q == CUP_LAST)
                    state_d = S_FAULT;
            end
            S_HEAT: begin
                if (temp_ok)
                    state_d = S_BREW;
            end
            S_BREW: begin
                if (cnt_q == BREW_LAST) begin
                    if (chg_q[0])
                        state_d = S_CHG5;
                    else if (chg_q[1])
                        state_d = S_CHG10;
                    else
                        state_d = S_DONE;
                end
            end
            S_CHG5: begin
                if (coin_ack) begin
                    chg_d[0] = 1'b0;
                    state_d  = chg_q[1] ? S_CHG10 : S_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_CHG10: begin
                if (coin_ack) begin
                    chg_d[1] = 1'b0;
                    state_d  = S_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Saturate so an indefinite HEAT or FAULT dwell never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = 8'd0;
        else if (cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            chg_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
        end
    end

    assign accept_coins = (state_q == S_IDLE);
    assign cup_drop     = (state_q == S_CUP) && (cnt_q == 8'd0);
    assign heater_on    = (state_q == S_HEAT);
    assign valve_open   = (state_q == S_BREW);
    assign coin5_eject  = (state_q == S_CHG5);
    assign coin10_eject = (state_q == S_CHG10);
    assign done         = (state_q == S_DONE);
    assign fault        = (state_q == S_FAULT);
    assign state        = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: expected per-cycle state/outputs are
// queued as stimulus is applied and compared on the falling edge.
module tb_vend_sequencer;

    localparam logic [2:0] IDLE = 3'd0, CUP = 3'd1, HEAT = 3'd2, BREW = 3'd3;
    localparam logic [2:0] CHG5 = 3'd4, CHG10 = 3'd5, DONE = 3'd6, FLT = 3'd7;

    logic       clk = 1'b0;
    logic       reset, pay_valid, cup_sense, temp_ok, coin_ack;
    logic [1:0] change_code;
    logic       accept_coins, cup_drop, heater_on, valve_open;
    logic       coin5_eject, coin10_eject, done, fault;
    logic [2:0] state;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;

    vend_sequencer dut (
        .clk(clk), .reset(reset), .pay_valid(pay_valid),
        .change_code(change_code), .cup_sense(cup_sense),
        .temp_ok(temp_ok), .coin_ack(coin_ack),
        .accept_coins(accept_coins), .cup_drop(cup_drop),
        .heater_on(heater_on), .valve_open(valve_open),
        .coin5_eject(coin5_eject), .coin10_eject(coin10_eject),
        .done(done), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [10:0] got,
                            input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got st=%0d outs=%b, expected st=%0d outs=%b",
                     tag, got[10:8], got[7:0], exp[10:8], exp[7:0]);
        end
    endtask

    // {state, accept, cup_drop, heater, valve, c5, c10, done, fault}
    function automatic logic [10:0] exp_vec(input logic [2:0] st, input bit cd);
        return {st, st == IDLE, cd, st == HEAT, st == BREW,
                st == CHG5, st == CHG10, st == DONE, st == FLT};
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            check_eq(it.tag, {state, accept_coins, cup_drop, heater_on,
                     valve_open, coin5_eject, coin10_eject, done, fault},
                     it.exp);
        end
    end

    // Clock one edge with the current inputs, then queue the expected result.
    task automatic step(input string tag, input logic [2:0] st, input bit cd = 0);
        sb_item_t it;
        @(posedge clk);
        #1;
        it.tag = tag;
        it.exp = exp_vec(st, cd);
        sb_q.push_back(it);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("reset", IDLE);
        reset = 1'b0;
    endtask

    task automatic pay(input string tag, input logic [1:0] code);
        pay_valid   = 1'b1;
        change_code = code;
        step({tag, "_cup"}, CUP, 1);
        pay_valid   = 1'b0;
        change_code = 2'b00;
    endtask

    task automatic brew_run(input string tag);
        step({tag, "_heat"}, HEAT);
        for (int i = 0; i < 16; i++)
            step($sformatf("%s_brew%0d", tag, i), BREW);
    endtask

    initial begin
        reset = 1'b1; pay_valid = 1'b0; change_code = 2'b00;
        cup_sense = 1'b0; temp_ok = 1'b0; coin_ack = 1'b0;
        do_reset();
        do_reset();

        // No change owed
        cup_sense = 1'b1; temp_ok = 1'b1;
        pay("nochg", 2'b00);
        brew_run("nochg");
        step("nochg_done", DONE);
        step("nochg_idle", IDLE);

        // 5c + 10c change, ack one cycle after each eject rises
        pay("both", 2'b11);
        brew_run("both");
        step("both_c5a", CHG5);
        step("both_c5b", CHG5);
        coin_ack = 1'b1;
        step("both_c10a", CHG10);
        coin_ack = 1'b0;
        step("both_c10b", CHG10);
        coin_ack = 1'b1;
        step("both_done", DONE);
        coin_ack = 1'b0;
        step("both_idle", IDLE);

        // 10c change, hopper never acks
        pay("ackto", 2'b10);
        brew_run("ackto");
        for (int i = 0; i < 8; i++)
            step($sformatf("ackto_c10_%0d", i), CHG10);
        step("ackto_fault", FLT);
        step("ackto_hold", FLT);
        do_reset();

        // Cup never arrives
        cup_sense = 1'b0;
        pay("cupto", 2'b00);
        for (int i = 1; i < 32; i++)
            step($sformatf("cupto_cup%0d", i), CUP);
        step("cupto_fault", FLT);
        do_reset();

        // Cup arrives in the last allowed cycle; heat without timeout
        temp_ok = 1'b0;
        pay("cupedge", 2'b11);
        for (int i = 1; i < 32; i++)
            step($sformatf("cupedge_cup%0d", i), CUP);
        cup_sense = 1'b1;
        for (int i = 0; i < 40; i++)
            step($sformatf("cupedge_heat%0d", i), HEAT);

        // Reset during brew, with a competing pay_valid
        temp_ok = 1'b1;
        do_reset();
        pay("midrst", 2'b11);
        step("midrst_heat", HEAT);
        for (int i = 0; i < 6; i++)
            step($sformatf("midrst_brew%0d", i), BREW);
        reset = 1'b1; pay_valid = 1'b1; change_code = 2'b11;
        step("midrst_rst", IDLE);
        reset = 1'b0; pay_valid = 1'b0; change_code = 2'b00;
        step("midrst_idle", IDLE);
        pay("after", 2'b00);
        brew_run("after");
        step("after_done", DONE);
        step("after_idle", IDLE);

        // pay_valid in HEAT and coin_ack in BREW are ignored
        temp_ok = 1'b0;
        pay("ign", 2'b00);
        step("ign_heat0", HEAT);
        pay_valid = 1'b1; change_code = 2'b11;
        step("ign_heat1", HEAT);
        pay_valid = 1'b0; change_code = 2'b00;
        step("ign_heat2", HEAT);
        temp_ok = 1'b1; coin_ack = 1'b1;
        for (int i = 0; i < 16; i++)
            step($sformatf("ign_brew%0d", i), BREW);
        step("ign_done", DONE);
        coin_ack = 1'b0;
        step("ign_idle", IDLE);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb_q.size() > 0)
            check_eq("drain", 11'(sb_q.size()), 11'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
